// File: rtl/pwr_seq_pkg.sv
// Shared state encoding and counter sizing helper for the pwr_seq power/clear sequencer.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_PON  = 3'd1,
    S_CLR  = 3'd2,
    S_STAG = 3'd3,
    S_ON   = 3'd4,
    S_MCLR = 3'd5,
    S_POUT = 3'd6
  } state_t;

  // Width of the single phase counter: must hold the longest phase length.
  function automatic int cnt_width(input int t_off, input int t_pon, input int t_clr,
                                   input int t_pout, input int t_stag_total);
    int m;
    m = t_off;
    if (t_pon > m) m = t_pon;
    if (t_clr > m) m = t_clr;
    if (t_pout > m) m = t_pout;
    if (t_stag_total > m) m = t_stag_total;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pwr_seq_sync.sv
// 2-FF synchroniser for active-low request lines, idle (reset) value 1.
// Only compiled when PWR_SEQ_SYNC_EN is defined.
`ifdef PWR_SEQ_SYNC_EN
module pwr_seq_sync (
  input  logic clk,
  input  logic rst_,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/pwr_seq.sv
// Power-supply / clear sequencer: OFF -> PON -> CLR -> STAG -> ON, with MCLR/POUT side paths.
// Define PWR_SEQ_SYNC_EN to pass zoff_/rcl_/dcl_ through 2-FF synchronisers.
module pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int T_OFF  = 4,
  parameter int T_PON  = 8,
  parameter int T_CLR  = 6,
  parameter int T_STAG = 3,
  parameter int T_POUT = 5
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic           zoff_,
  input  logic           rcl_,
  input  logic           dcl_,
  output logic           off_,
  output logic           pout_,
  output logic           pon_,
  output logic           clo_,
  output logic [NCH-1:0] clm_,
  output logic           run_trig
);

  localparam int STAG_LEN = (NCH - 1) * T_STAG;
  localparam int CW       = cnt_width(T_OFF, T_PON, T_CLR, T_POUT, STAG_LEN);

  logic zoff_s, rcl_s, dcl_s;

`ifdef PWR_SEQ_SYNC_EN
  pwr_seq_sync u_sync_zoff (.clk(clk), .rst_(rst_), .d(zoff_), .q(zoff_s));
  pwr_seq_sync u_sync_rcl  (.clk(clk), .rst_(rst_), .d(rcl_),  .q(rcl_s));
  pwr_seq_sync u_sync_dcl  (.clk(clk), .rst_(rst_), .d(dcl_),  .q(dcl_s));
`else
  assign zoff_s = zoff_;
  assign rcl_s  = rcl_;
  assign dcl_s  = dcl_;
`endif

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            pwrup, pwrup_d;
  logic            off_d, pout_d, pon_d, clo_d, run_d;
  logic [NCH-1:0]  clm_d;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= S_OFF;
      cnt      <= '0;
      pwrup    <= 1'b1;
      off_     <= 1'b0;
      pout_    <= 1'b1;
      pon_     <= 1'b0;
      clo_     <= 1'b0;
      clm_     <= '0;
      run_trig <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pwrup    <= pwrup_d;
      off_     <= off_d;
      pout_    <= pout_d;
      pon_     <= pon_d;
      clo_     <= clo_d;
      clm_     <= clm_d;
      run_trig <= run_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    pwrup_d = pwrup;
    off_d   = off_;
    pout_d  = pout_;
    pon_d   = pon_;
    clo_d   = clo_;
    clm_d   = clm_;
    run_d   = 1'b0;

    case (state)
      S_OFF: begin
        if (!zoff_s) begin
          cnt_d = '0;
        end else if (cnt == CW'(T_OFF)) begin
          state_d = S_PON;
          cnt_d   = '0;
        end
      end
      S_POUT: begin
        if (cnt == CW'(T_POUT - 1)) begin
          state_d = S_OFF;
          cnt_d   = '0;
          pwrup_d = 1'b1;
        end
      end
      default: begin
        // Requests: zoff_ beats dcl_ beats rcl_; each phase ignores what it cannot act on.
        if (!zoff_s) begin
          state_d = S_POUT;
          cnt_d   = '0;
        end else begin
          case (state)
            S_PON: begin
              if (cnt == CW'(T_PON - 1)) begin
                state_d = S_CLR;
                cnt_d   = '0;
              end
            end
            S_CLR: begin
              if (!dcl_s) begin
                cnt_d = '0;
              end else if (cnt == CW'(T_CLR - 1)) begin
                state_d = (STAG_LEN == 0) ? S_ON : S_STAG;
                cnt_d   = '0;
              end
            end
            S_STAG: begin
              if (!dcl_s) begin
                state_d = S_CLR;
                cnt_d   = '0;
              end else if (cnt == CW'(STAG_LEN - 1)) begin
                state_d = S_ON;
                cnt_d   = '0;
              end
            end
            S_ON: begin
              cnt_d = cnt;
              if (!dcl_s) begin
                state_d = S_CLR;
                cnt_d   = '0;
              end else if (!rcl_s) begin
                state_d = S_MCLR;
                cnt_d   = '0;
              end
            end
            S_MCLR: begin
              if (!dcl_s) begin
                state_d = S_CLR;
                cnt_d   = '0;
              end else if (!rcl_s) begin
                cnt_d = '0;
              end else if (cnt == CW'(T_CLR - 1)) begin
                state_d = S_ON;
                cnt_d   = '0;
              end
            end
            default: begin
              state_d = S_OFF;
              cnt_d   = '0;
            end
          endcase
        end
      end
    endcase

    if (state_d == S_ON && state != S_ON) begin
      run_d   = pwrup;
      pwrup_d = 1'b0;
    end

    // Outputs are registered from the next state so they change on the transition edge.
    case (state_d)
      S_OFF: begin
        off_d  = 1'b0;
        pout_d = 1'b1;
        pon_d  = 1'b0;
        clo_d  = 1'b0;
        clm_d  = '0;
      end
      S_PON: begin
        off_d  = 1'b1;
        pout_d = 1'b1;
        pon_d  = 1'b0;
        clo_d  = 1'b0;
        clm_d  = '0;
      end
      S_CLR: begin
        off_d  = 1'b1;
        pout_d = 1'b1;
        pon_d  = 1'b1;
        clo_d  = 1'b0;
        clm_d  = '0;
      end
      S_STAG: begin
        off_d  = 1'b1;
        pout_d = 1'b1;
        pon_d  = 1'b1;
        clo_d  = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          clm_d[i] = (32'(cnt_d) >= 32'(i * T_STAG));
        end
      end
      S_ON: begin
        off_d  = 1'b1;
        pout_d = 1'b1;
        pon_d  = 1'b1;
        clo_d  = 1'b1;
        clm_d  = '1;
      end
      S_MCLR: begin
        off_d  = 1'b1;
        pout_d = 1'b1;
        pon_d  = 1'b1;
        clo_d  = 1'b1;
        clm_d  = '0;
      end
      S_POUT: begin
        pout_d = 1'b0;
      end
      default: begin
        off_d  = 1'b0;
        pout_d = 1'b1;
        pon_d  = 1'b0;
        clo_d  = 1'b0;
        clm_d  = '0;
      end
    endcase
  end

endmodule
